// File: rtl/l2_bank_arbiter.sv
// Round-robin N:1 arbiter in front of one L2 bank port; routes in-order responses back by ID FIFO.
// Latency: zero added; req->gnt, req->b_req and b_r_valid->m_r_valid are all combinational.
// Backpressure: b_req_o is held low while the ID FIFO is full, unless a response pops it this cycle.
// Optional: define L2_BANK_ARB_BURST_LOCK_EN to keep granting one master for up to MAX_BURST beats.
module l2_bank_arbiter #(
    parameter int NB_MASTERS = 2,
    parameter int RESP_DEPTH = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_MASTERS-1:0]        m_req_i,
    input  logic [NB_MASTERS-1:0][31:0]  m_add_i,
    input  logic [NB_MASTERS-1:0]        m_wen_i,
    input  logic [NB_MASTERS-1:0][3:0]   m_be_i,
    input  logic [NB_MASTERS-1:0][35:0]  m_wdata_i,
    output logic [NB_MASTERS-1:0]        m_gnt_o,
    output logic [NB_MASTERS-1:0]        m_r_valid_o,
    output logic [NB_MASTERS-1:0][35:0]  m_r_rdata_o,
    output logic [NB_MASTERS-1:0]        m_r_opc_o,
    output logic                         b_req_o,
    output logic [31:0]                  b_add_o,
    output logic                         b_wen_o,
    output logic [3:0]                   b_be_o,
    output logic [35:0]                  b_wdata_o,
    input  logic                         b_gnt_i,
    input  logic                         b_r_valid_i,
    input  logic [35:0]                  b_r_rdata_i,
    input  logic                         b_r_opc_i,
    output logic                         err_o
);

    localparam int IDW = $clog2(NB_MASTERS);
    localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);

    if (NB_MASTERS < 2 || NB_MASTERS > 8 || RESP_DEPTH < 1 || RESP_DEPTH > 8 ||
        MAX_BURST < 1 || MAX_BURST > 16) begin : g_param_check
        $error("l2_bank_arbiter: parameter out of range");
    end

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] head;
    logic           found;
    int             idx;

    logic [IDW-1:0] id_mem [2**PW];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           pop;
    logic           push;
    logic           bank_req;
    logic           err;

    function automatic logic [PW-1:0] fifo_next(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IDW-1:0] id_next(input logic [IDW-1:0] p);
        return (p == IDW'(NB_MASTERS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at ptr; reset masks every request so outputs stay quiet.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NB_MASTERS) begin
                idx = idx - NB_MASTERS;
            end
            cand = IDW'(idx);
            if (!found && m_req_i[cand] && !rst_i) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign full     = (count == CW'(RESP_DEPTH));
    assign pop      = b_r_valid_i && (count != '0) && !rst_i;
    assign bank_req = found && (!full || pop);
    assign push     = bank_req && b_gnt_i;
    assign head     = id_mem[rd_ptr];
    assign err_o    = err;

    // Bank request mux, grant steering and response fan-out.
    always_comb begin
        b_req_o     = bank_req;
        b_add_o     = found ? m_add_i[win]   : '0;
        b_wen_o     = found ? m_wen_i[win]   : 1'b0;
        b_be_o      = found ? m_be_i[win]    : '0;
        b_wdata_o   = found ? m_wdata_i[win] : '0;
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (push) begin
            m_gnt_o[win] = 1'b1;
        end
        if (pop) begin
            m_r_valid_o[head] = 1'b1;
        end
        for (int i = 0; i < NB_MASTERS; i++) begin
            m_r_rdata_o[i] = b_r_rdata_i;
            m_r_opc_o[i]   = b_r_opc_i;
        end
    end

    // ID storage; writes only happen on an accepted request, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= win;
        end
    end

    // ID FIFO pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= fifo_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= fifo_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky flag for a bank response that has no outstanding request to match.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (b_r_valid_i && (count == '0)) begin
            err <= 1'b1;
        end
    end

`ifdef L2_BANK_ARB_BURST_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] bcnt;

    // Priority pointer with burst lock: stay on the winner until MAX_BURST grants, then rotate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr  <= '0;
            bcnt <= '0;
        end else if (push) begin
            if ((win == ptr) && (int'(bcnt) + 1 < MAX_BURST)) begin
                bcnt <= bcnt + 1'b1;
            end else if ((win != ptr) && (MAX_BURST > 1)) begin
                ptr  <= win;
                bcnt <= BW'(1);
            end else begin
                ptr  <= id_next(win);
                bcnt <= '0;
            end
        end else if (!m_req_i[ptr]) begin
            bcnt <= '0;
        end
    end
`else
    // Priority pointer moves just past the master granted this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= id_next(win);
        end
    end
`endif

endmodule
